// File: rtl/regfile_rd2_wr1.sv
// 2**ADDR_W x DATA_W register file: one write port and two read ports. Reads are registered (1 cycle) and bypass a same-cycle write.
// rd_en=0 stalls the read side: the data outputs hold and rd_valid drops. Writes are never stalled.
module regfile_rd2_wr1 #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data0,
  output logic [DATA_W-1:0] rd_data1,
  output logic              rd_valid
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  wr_sel;
  logic [DATA_W-1:0] rd_nxt0;
  logic [DATA_W-1:0] rd_nxt1;

  // Register 0 is hard-wired when ZERO_REG is set, so its write enable is never decoded.
  always_comb begin
    wr_sel = '0;
    if (wr_en) wr_sel[wr_addr] = 1'b1;
    if (ZERO_REG != 0) wr_sel[0] = 1'b0;
  end

  function automatic logic [DATA_W-1:0] read_val(
    input logic [ADDR_W-1:0] a,
    input logic              w_en,
    input logic [ADDR_W-1:0] w_addr,
    input logic [DATA_W-1:0] w_data,
    input logic [DATA_W-1:0] arr_val
  );
    logic [DATA_W-1:0] v;
    v = arr_val;
    if (w_en && (w_addr == a)) v = w_data;
    if ((ZERO_REG != 0) && (a == '0)) v = '0;
    return v;
  endfunction

  always_comb begin
    rd_nxt0 = read_val(rd_addr0, wr_en, wr_addr, wr_data, regs[rd_addr0]);
    rd_nxt1 = read_val(rd_addr1, wr_en, wr_addr, wr_data, regs[rd_addr1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      rd_data0 <= '0;
      rd_data1 <= '0;
      rd_valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) regs[i] <= wr_data;
      end
      if (rd_en) begin
        rd_data0 <= rd_nxt0;
        rd_data1 <= rd_nxt1;
        rd_valid <= 1'b1;
      end else begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule
